ltl_automata_engine: RTL and testbench

LTL_AUTOMATA_ENGINE -- requirements
Module: ltl_automata_engine

---
 rtl/ltl_automata_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_ltl_automata_engine.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltl_automata_engine.sv
// ---------------------------------------------------------------------------
// ltl_automata_engine
//
// Purpose: Homogeneous automata engine built from NUM_STE state-transition
// elements (STEs). Each STE owns a 2^SYM_W-bit match table; an STE becomes
// active on an accepted symbol when it is enabled (by an active predecessor
// through the adjacency table, by start-all, or by start-of-data on the first
// symbol of a stream) and its match table hits that symbol. Whenever a
// reporting STE becomes active, a report {active report STEs, symbol offset}
// is queued for the consumer.
//
// Configuration macro: LTL_ENG_REPORT_FIFO_EN
//   defined   -> report path is a RPT_DEPTH-entry FIFO
//   undefined -> report path is a single-entry register (RPT_DEPTH unused)
//
// Ports:
//   clk        in  1        single clock
//   reset      in  1        synchronous active-low reset
//   cfg_we     in  1        configuration write strobe
//   cfg_sel    in  2        0 match table, 1 adjacency, 2 start/report attrs
//   cfg_idx    in  6        target STE index (>= NUM_STE ignored)
//   cfg_addr   in  SYM_W    bit address within the selected table
//   cfg_data   in  2        write data
//   run        in  1        enable matching
//   sym_valid  in  1        input symbol valid
//   sym_ready  out 1        engine can accept a symbol
//   sym        in  SYM_W    input symbol
//   sym_last   in  1        final symbol of the stream
//   rpt_valid  out 1        report available
//   rpt_ready  in  1        consumer takes the report
//   rpt_vec    out NUM_STE  report STEs active on the reporting symbol
//   rpt_off    out CNT_W    offset of the reporting symbol
//   rpt_ovf    out 1        sticky report overflow flag
// ---------------------------------------------------------------------------
module ltl_automata_engine #(
    parameter int NUM_STE   = 16,
    parameter int SYM_W     = 8,
    parameter int RPT_DEPTH = 4,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [5:0]         cfg_idx,
    input  logic [SYM_W-1:0]   cfg_addr,
    input  logic [1:0]         cfg_data,
    input  logic               run,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [SYM_W-1:0]   sym,
    input  logic               sym_last,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [NUM_STE-1:0] rpt_vec,
    output logic [CNT_W-1:0]   rpt_off,
    output logic               rpt_ovf
);

    localparam int TBL_W = 1 << SYM_W;
    localparam int IDX_W = (NUM_STE > 1) ? $clog2(NUM_STE) : 1;

    // Elaboration-time parameter sanity checks.
    if (NUM_STE < 2 || NUM_STE > 64) begin : g_bad_num_ste
        $error("NUM_STE must be in 2..64");
    end
    if (RPT_DEPTH < 2 || (RPT_DEPTH & (RPT_DEPTH - 1)) != 0) begin : g_bad_rpt_depth
        $error("RPT_DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic [NUM_STE-1:0] vec;
        logic [CNT_W-1:0]   off;
    } rpt_t;

    // Configuration tables
    logic [TBL_W-1:0]   match_q [NUM_STE];
    logic [NUM_STE-1:0] adj_q   [NUM_STE];   // adj_q[j][i]: edge from STE j to STE i
    logic [NUM_STE-1:0] start_sod_q;
    logic [NUM_STE-1:0] start_all_q;
    logic [NUM_STE-1:0] rpt_mask_q;

    // Matching state
    logic [NUM_STE-1:0] active_q, active_d;
    logic [NUM_STE-1:0] active_nxt;
    logic [NUM_STE-1:0] enable;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               enq;
    logic               deq;
    logic               path_full;
    rpt_t               enq_ent;
    rpt_t               head_ent;

    // Configuration decode
    logic [IDX_W-1:0]   ste_idx;
    logic [IDX_W-1:0]   addr_idx;
    logic               idx_ok;
    logic               addr_ok;

    assign ste_idx  = IDX_W'(cfg_idx);
    assign addr_idx = IDX_W'(cfg_addr);
    assign idx_ok   = int'(cfg_idx) < NUM_STE;
    assign addr_ok  = int'(cfg_addr) < NUM_STE;

    // NOTE: the configuration tables are deliberately left out of reset: they
    // must survive a reset, and a reset on a wide table would also prevent it
    // from mapping onto plain storage.
    always_ff @(posedge clk) begin
        if (cfg_we && idx_ok) begin
            case (cfg_sel)
                2'd0: match_q[ste_idx][cfg_addr] <= cfg_data[0];
                2'd1: begin
                    if (addr_ok) adj_q[ste_idx][addr_idx] <= cfg_data[0];
                end
                2'd2: begin
                    if (cfg_addr == '0) begin
                        start_sod_q[ste_idx] <= cfg_data[0];
                        start_all_q[ste_idx] <= cfg_data[1];
                    end else if (cfg_addr == SYM_W'(1)) begin
                        rpt_mask_q[ste_idx] <= cfg_data[0];
                    end
                end
                default: ;
            endcase
        end
    end

    // A config write blocks acceptance, so table updates are always seen by
    // the next accepted symbol and never race with one.
    assign sym_ready = reset & run & ~cfg_we & ~path_full;
    assign accept    = sym_valid & sym_ready;
    assign deq       = rpt_valid & rpt_ready;

    // NOTE: combinational logic uses blocking assignments and gives every
    // output a default first, so no latch can be inferred.
    always_comb begin
        enable = start_all_q | (first_q ? start_sod_q : '0);
        for (int j = 0; j < NUM_STE; j++) begin
            if (active_q[j]) enable = enable | adj_q[j];
        end
        active_nxt = '0;
        for (int i = 0; i < NUM_STE; i++) begin
            active_nxt[i] = match_q[i][sym] & enable[i];
        end
    end

    always_comb begin
        enq_ent.vec = active_nxt & rpt_mask_q;
        enq_ent.off = cnt_q;
        enq         = accept & (|enq_ent.vec);

        active_d = active_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        if (accept) begin
            // A last symbol still reports from active_nxt before the clear.
            active_d = sym_last ? '0 : active_nxt;
            cnt_d    = sym_last ? '0 : cnt_q + CNT_W'(1);
            first_d  = sym_last;
        end
        ovf_d = ovf_q | (enq & path_full & ~deq);
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef LTL_ENG_REPORT_FIFO_EN
    localparam int PTR_W = $clog2(RPT_DEPTH);

    rpt_t             fifo_q [RPT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   fill_q;
    logic             push;

    assign path_full = (fill_q == (PTR_W+1)'(RPT_DEPTH));
    assign rpt_valid = (fill_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = enq & (~path_full | deq);
    assign head_ent  = fifo_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= enq_ent;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (deq)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, deq})
                2'b10:   fill_q <= fill_q + (PTR_W+1)'(1);
                2'b01:   fill_q <= fill_q - (PTR_W+1)'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end
`else
    logic valid_q;
    rpt_t ent_q;
    logic push;

    assign path_full = valid_q;
    assign rpt_valid = valid_q;
    assign push      = enq & (~path_full | deq);
    assign head_ent  = ent_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ent_q   <= '0;
        end else if (push) begin
            valid_q <= 1'b1;
            ent_q   <= enq_ent;
        end else if (deq) begin
            valid_q <= 1'b0;
        end
    end
`endif

    // Data outputs read as zero whenever no report is presented.
    assign rpt_vec = rpt_valid ? head_ent.vec : '0;
    assign rpt_off = rpt_valid ? head_ent.off : '0;
    assign rpt_ovf = ovf_q;

endmodule

// File: tb/tb_ltl_automata_engine.sv
module tb_ltl_automata_engine;

    localparam int NS = 16;
`ifdef LTL_ENG_REPORT_FIFO_EN
    localparam int EFF_DEPTH = 4;
`else
    localparam int EFF_DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = '0;
    logic [5:0]  cfg_idx = '0;
    logic [7:0]  cfg_addr = '0;
    logic [1:0]  cfg_data = '0;
    logic        run = 1'b0;
    logic        sym_valid = 1'b0;
    logic [7:0]  sym = '0;
    logic        sym_last = 1'b0;
    logic        rpt_ready = 1'b0;

    logic        sym_ready, rpt_valid, rpt_ovf;
    logic [15:0] rpt_vec;
    logic [31:0] rpt_off;
    logic        sym_ready_w, rpt_valid_w, rpt_ovf_w;
    logic [15:0] rpt_vec_w;
    logic [3:0]  rpt_off_w;

    always #5 clk = ~clk;

    ltl_automata_engine #(.NUM_STE(NS), .SYM_W(8), .RPT_DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .run(run), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .sym(sym), .sym_last(sym_last), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_vec(rpt_vec), .rpt_off(rpt_off), .rpt_ovf(rpt_ovf)
    );

    // Narrow-counter instance on the same stimulus, for offset wrap behaviour.
    ltl_automata_engine #(.NUM_STE(NS), .SYM_W(8), .RPT_DEPTH(4), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .run(run), .sym_valid(sym_valid),
        .sym_ready(sym_ready_w), .sym(sym), .sym_last(sym_last), .rpt_valid(rpt_valid_w),
        .rpt_ready(rpt_ready), .rpt_vec(rpt_vec_w), .rpt_off(rpt_off_w), .rpt_ovf(rpt_ovf_w)
    );

    // ---------------- reference model (set/queue level) ----------------
    bit mt   [NS][256];
    bit adjm [NS][NS];
    bit sod  [NS];
    bit sall [NS];
    bit mask [NS];
    bit act  [NS];
    bit first_m = 1'b1;
    int unsigned offc = 0;

    typedef struct { logic [15:0] vec; int unsigned off; } exp_t;
    exp_t mq[$];

    typedef struct { logic [15:0] vec; logic [31:0] off; logic [15:0] vec_w; logic [3:0] off_w; } got_t;
    got_t got[$];

    int n_acc = 0;       // symbols the model says were accepted
    int n_dut_acc = 0;   // symbols the DUT handshake shows were accepted

    always @(posedge clk) begin
        bit acc;
        bit en;
        bit nxt [NS];
        logic [15:0] rv;
        int ci, ca, s;
        acc = reset && run && sym_valid && !cfg_we && (mq.size() < EFF_DEPTH);
        ci = int'(cfg_idx);
        ca = int'(cfg_addr);
        if (cfg_we && ci < NS) begin
            case (cfg_sel)
                2'd0: mt[ci][ca] = cfg_data[0];
                2'd1: if (ca < NS) adjm[ci][ca] = cfg_data[0];
                2'd2: begin
                    if (ca == 0) begin sod[ci] = cfg_data[0]; sall[ci] = cfg_data[1]; end
                    else if (ca == 1) mask[ci] = cfg_data[0];
                end
                default: ;
            endcase
        end
        if (sym_valid && sym_ready && run) n_dut_acc++;
        if (!reset) begin
            for (int i = 0; i < NS; i++) act[i] = 1'b0;
            first_m = 1'b1;
            offc = 0;
            mq.delete();
        end else begin
            if (rpt_valid && rpt_ready)
                got.push_back('{rpt_vec, rpt_off, rpt_vec_w, rpt_off_w});
            if (mq.size() > 0 && rpt_ready) void'(mq.pop_front());
            if (acc) begin
                s = int'(sym);
                rv = '0;
                for (int i = 0; i < NS; i++) begin
                    en = sall[i] || (sod[i] && first_m);
                    for (int j = 0; j < NS; j++) if (act[j] && adjm[j][i]) en = 1'b1;
                    nxt[i] = mt[i][s] && en;
                    if (nxt[i] && mask[i]) rv[i] = 1'b1;
                end
                if (rv != 0) mq.push_back('{rv, offc});
                if (sym_last) begin
                    for (int i = 0; i < NS; i++) act[i] = 1'b0;
                    offc = 0;
                    first_m = 1'b1;
                end else begin
                    for (int i = 0; i < NS; i++) act[i] = nxt[i];
                    offc++;
                    first_m = 1'b0;
                end
                n_acc++;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got_v, exp_v, $time);
        end
    endtask

    // Advance one cycle and compare every output against the model at the
    // falling edge.
    task automatic tick();
        logic exp_ready;
        @(negedge clk);
        exp_ready = reset && run && !cfg_we && (mq.size() < EFF_DEPTH);
        check("sym_ready", sym_ready, exp_ready);
        check("sym_ready_w", sym_ready_w, exp_ready);
        check("rpt_valid", rpt_valid, mq.size() > 0);
        check("rpt_valid_w", rpt_valid_w, mq.size() > 0);
        if (mq.size() > 0) begin
            check("rpt_vec", rpt_vec, mq[0].vec);
            check("rpt_off", rpt_off, mq[0].off);
            check("rpt_vec_w", rpt_vec_w, mq[0].vec);
            check("rpt_off_w", rpt_off_w, mq[0].off % 16);
        end
        check("rpt_ovf", rpt_ovf, 0);
        check("rpt_ovf_w", rpt_ovf_w, 0);
    endtask

    task automatic cfg_wr(input int sel, input int idx, input int addr, input int data);
        cfg_we = 1'b1;
        cfg_sel = 2'(sel);
        cfg_idx = 6'(idx);
        cfg_addr = 8'(addr);
        cfg_data = 2'(data);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++)
            for (int a = 0; a < 256; a++) cfg_wr(0, i, a, 0);
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < NS; j++) cfg_wr(1, i, j, 0);
        for (int i = 0; i < NS; i++) begin
            cfg_wr(2, i, 0, 0);
            cfg_wr(2, i, 1, 0);
        end
    endtask

    task automatic do_reset();
        sym_valid = 1'b0;
        sym_last = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic setup_scen(input int sc);
        clear_all();
        if (sc == 0) begin
            for (int a = 0; a < 16; a++) cfg_wr(0, 0, a, 1);
            cfg_wr(2, 0, 0, 1);
            cfg_wr(2, 0, 1, 1);
        end else begin
            cfg_wr(0, 0, 'h41, 1);
            cfg_wr(0, 1, 'h42, 1);
            cfg_wr(1, 0, 1, 1);
            cfg_wr(2, 0, 0, 1);
            cfg_wr(2, 1, 1, 1);
        end
        do_reset();
    endtask

    typedef struct {
        int          scen;
        logic [7:0]  s;
        logic        last;
        logic        exp_v;
        logic [15:0] exp_vec;
        logic [31:0] exp_off;
    } vec_t;

    initial begin
        vec_t tbl [15];
        int cur;
        int base;
        int dbase;

        tbl[0]  = '{0, 8'h05, 1'b1, 1'b1, 16'h0001, 32'd0};
        tbl[1]  = '{0, 8'h05, 1'b1, 1'b1, 16'h0001, 32'd0};
        tbl[2]  = '{0, 8'h10, 1'b1, 1'b0, 16'h0000, 32'd0};
        tbl[3]  = '{0, 8'h20, 1'b0, 1'b0, 16'h0000, 32'd0};
        tbl[4]  = '{0, 8'h05, 1'b0, 1'b0, 16'h0000, 32'd0};
        tbl[5]  = '{0, 8'h05, 1'b1, 1'b0, 16'h0000, 32'd0};
        tbl[6]  = '{0, 8'h0F, 1'b1, 1'b1, 16'h0001, 32'd0};
        tbl[7]  = '{1, 8'h41, 1'b0, 1'b0, 16'h0000, 32'd0};
        tbl[8]  = '{1, 8'h42, 1'b0, 1'b1, 16'h0002, 32'd1};
        tbl[9]  = '{1, 8'h42, 1'b1, 1'b0, 16'h0000, 32'd0};
        tbl[10] = '{1, 8'h41, 1'b0, 1'b0, 16'h0000, 32'd0};
        tbl[11] = '{1, 8'h41, 1'b0, 1'b0, 16'h0000, 32'd0};
        tbl[12] = '{1, 8'h42, 1'b1, 1'b0, 16'h0000, 32'd0};
        tbl[13] = '{1, 8'h41, 1'b0, 1'b0, 16'h0000, 32'd0};
        tbl[14] = '{1, 8'h42, 1'b1, 1'b1, 16'h0002, 32'd1};

        // Reset state, with run high to show reset gates sym_ready.
        run = 1'b1;
        tick();
        tick();
        check("rst_sym_ready", sym_ready, 0);
        check("rst_rpt_valid", rpt_valid, 0);
        check("rst_rpt_vec", rpt_vec, 0);
        check("rst_rpt_off", rpt_off, 0);
        check("rst_rpt_ovf", rpt_ovf, 0);
        reset = 1'b1;

        // Table-driven single-symbol vectors.
        cur = -1;
        for (int k = 0; k < 15; k++) begin
            if (tbl[k].scen != cur) begin
                cur = tbl[k].scen;
                setup_scen(cur);
            end
            rpt_ready = 1'b1;
            sym = tbl[k].s;
            sym_last = tbl[k].last;
            sym_valid = 1'b1;
            tick();
            sym_valid = 1'b0;
            sym_last = 1'b0;
            check($sformatf("tbl%0d_valid", k), rpt_valid, tbl[k].exp_v);
            if (tbl[k].exp_v) begin
                check($sformatf("tbl%0d_vec", k), rpt_vec, tbl[k].exp_vec);
                check($sformatf("tbl%0d_off", k), rpt_off, tbl[k].exp_off);
            end
            tick();
        end

        // Backpressure: start_all STE3 on 0xFF, consumer stalled.
        clear_all();
        cfg_wr(0, 3, 'hFF, 1);
        cfg_wr(2, 3, 0, 2);
        cfg_wr(2, 3, 1, 1);
        do_reset();
        rpt_ready = 1'b0;
        sym = 8'hFF;
        sym_valid = 1'b1;
        base = n_acc;
        dbase = n_dut_acc;
        repeat (12) tick();
        check("stall_accepts", n_dut_acc - dbase, EFF_DEPTH);
        check("stall_ready", sym_ready, 0);
        got.delete();
        rpt_ready = 1'b1;
        for (int t = 0; t < 200 && got.size() < 8; t++) begin
            if (n_acc - base >= 8) begin
                sym_valid = 1'b0;
                sym_last = 1'b0;
            end else begin
                sym_last = (n_acc - base == 7);
            end
            tick();
        end
        sym_valid = 1'b0;
        sym_last = 1'b0;
        check("bp_report_count", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) begin
            check($sformatf("bp_off%0d", i), got[i].off, i);
            check($sformatf("bp_vec%0d", i), got[i].vec, 16'h0008);
        end
        check("bp_ovf", rpt_ovf, 0);

        // Reset mid-stream with reports queued; tables must survive.
        do_reset();
        rpt_ready = 1'b0;
        sym = 8'hFF;
        sym_valid = 1'b1;
        repeat (6) tick();
        check("mid_valid_before", rpt_valid, 1);
        reset = 1'b0;
        sym_valid = 1'b0;
        tick();
        check("mid_rst_valid", rpt_valid, 0);
        check("mid_rst_vec", rpt_vec, 0);
        check("mid_rst_off", rpt_off, 0);
        check("mid_rst_ready", sym_ready, 0);
        reset = 1'b1;
        got.delete();
        rpt_ready = 1'b1;
        sym_valid = 1'b1;
        sym_last = 1'b1;
        tick();
        sym_valid = 1'b0;
        sym_last = 1'b0;
        tick();
        tick();
        check("mid_post_count", got.size(), 1);
        if (got.size() > 0) begin
            check("mid_post_off", got[0].off, 0);
            check("mid_post_vec", got[0].vec, 16'h0008);
        end

        // Self-loop STE2 over every symbol; narrow counter wraps 15 -> 0.
        clear_all();
        for (int a = 0; a < 256; a++) cfg_wr(0, 2, a, 1);
        cfg_wr(1, 2, 2, 1);
        cfg_wr(2, 2, 0, 1);
        cfg_wr(2, 2, 1, 1);
        do_reset();
        got.delete();
        rpt_ready = 1'b1;
        sym_valid = 1'b1;
        base = n_acc;
        for (int t = 0; t < 300 && got.size() < 18; t++) begin
            sym = 8'($urandom);
            if (n_acc - base >= 18) begin
                sym_valid = 1'b0;
                sym_last = 1'b0;
            end else begin
                sym_last = (n_acc - base == 17);
            end
            tick();
        end
        sym_valid = 1'b0;
        sym_last = 1'b0;
        check("wrap_report_count", got.size(), 18);
        for (int i = 0; i < got.size() && i < 18; i++) begin
            check($sformatf("wrap_off%0d", i), got[i].off, i);
            check($sformatf("wrap_offw%0d", i), got[i].off_w, i % 16);
            check($sformatf("wrap_vec%0d", i), got[i].vec, 16'h0004);
        end

        // Randomized traffic against the model.
        clear_all();
        for (int i = 0; i < NS; i++) begin
            for (int a = 0; a < 8; a++) cfg_wr(0, i, a, int'(($urandom % 3) == 0));
            for (int j = 0; j < NS; j++) cfg_wr(1, i, j, int'(($urandom % 6) == 0));
            cfg_wr(2, i, 0, int'({($urandom % 5) == 0, ($urandom % 3) == 0}));
            cfg_wr(2, i, 1, int'($urandom % 2));
        end
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            reset = ($urandom % 300) != 0;
            run = ($urandom % 10) != 0;
            sym_valid = ($urandom % 10) < 7;
            sym = (($urandom % 16) == 0) ? 8'($urandom) : 8'($urandom % 8);
            sym_last = ($urandom % 10) == 0;
            rpt_ready = ($urandom % 10) < 6;
            cfg_we = ($urandom % 40) == 0;
            cfg_sel = 2'($urandom);
            cfg_idx = 6'($urandom % 32);
            cfg_addr = 8'($urandom % 32);
            cfg_data = 2'($urandom);
            tick();
        end
        reset = 1'b1;
        run = 1'b1;
        cfg_we = 1'b0;
        sym_valid = 1'b0;
        sym_last = 1'b0;
        rpt_ready = 1'b1;
        repeat (10) tick();
        check("drain_valid", rpt_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
